// File: rtl/hub75_pkg.sv
// Shared types and default widths for the HUB75 scan engine.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  localparam int unsigned PIX_W  = $clog2(128) + 1;
  localparam int unsigned LINE_W = $clog2(32) + 1;

endpackage

// File: rtl/hub75_half_tick.sv
// Panel-clock half-period timer: one-cycle tick every HALF_PERIOD cycles,
// phase-aligned to the cycle after restart.
module hub75_half_tick
  import hub75_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: shifts a row pair, blanks, latches, addresses and
// displays it, line by line, feeding counters to the sprite stage.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_PIXELS     = 128,
  parameter int unsigned NUM_LINES      = 32,
  parameter int unsigned HALF_PERIOD    = 1,
  parameter int unsigned DISPLAY_CYCLES = 64
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           enable_in,
  input  logic [2:0]                     rgb0_in,
  input  logic [2:0]                     rgb1_in,
  output logic [$clog2(NUM_PIXELS):0]    pixel_counter_out,
  output logic [$clog2(NUM_LINES):0]     line_counter_out,
  output logic [2:0]                     rgb0_out,
  output logic [2:0]                     rgb1_out,
  output logic                           panel_clk_out,
  output logic                           latch_out,
  output logic                           oe_n_out,
  output logic [$clog2(NUM_LINES)-1:0]   addr_out,
  output logic                           frame_done_out
);

  localparam int unsigned PW = $clog2(NUM_PIXELS) + 1;
  localparam int unsigned LW = $clog2(NUM_LINES) + 1;
  localparam int unsigned AW = $clog2(NUM_LINES);
  localparam int unsigned DW = $clog2(DISPLAY_CYCLES + 1);

  localparam logic [PW-1:0] PIX_END   = PW'(NUM_PIXELS);
  localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINES - 1);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISPLAY_CYCLES - 1);

  state_t        state_q, state_d;
  logic          tick;
  logic          shift_entry;
  logic          shift_done;
  logic          disp_done;
  logic [DW-1:0] disp_cnt;

  assign shift_done = tick && panel_clk_out && (pixel_counter_out == PIX_END);
  assign disp_done  = (disp_cnt == DISP_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_in) state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = BLANK;
      BLANK:   state_d = LATCH;
      LATCH:   state_d = DISPLAY;
      DISPLAY: if (disp_done) state_d = enable_in ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
    shift_entry = (state_d == SHIFT) && (state_q != SHIFT);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  hub75_half_tick #(.HALF_PERIOD(HALF_PERIOD)) u_half_tick (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .restart (shift_entry),
    .tick    (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_counter_out <= '0;
      line_counter_out  <= '0;
      rgb0_out          <= '0;
      rgb1_out          <= '0;
      panel_clk_out     <= 1'b0;
      latch_out         <= 1'b0;
      oe_n_out          <= 1'b1;
      addr_out          <= '0;
      frame_done_out    <= 1'b0;
      disp_cnt          <= '0;
    end else begin
      frame_done_out <= 1'b0;
      case (state_q)
        IDLE: begin
          oe_n_out          <= 1'b1;
          panel_clk_out     <= 1'b0;
          pixel_counter_out <= '0;
        end
        SHIFT: begin
          oe_n_out <= 1'b1;
          // Pixel 0 is captured on the entry cycle; its low half overlaps it,
          // so each pixel costs exactly 2*HALF_PERIOD cycles.
          if (pixel_counter_out == '0) begin
            rgb0_out          <= rgb0_in;
            rgb1_out          <= rgb1_in;
            pixel_counter_out <= pixel_counter_out + PW'(1);
          end
          if (tick) begin
            if (!panel_clk_out) begin
              panel_clk_out <= 1'b1;
            end else begin
              panel_clk_out <= 1'b0;
              if (pixel_counter_out != PIX_END) begin
                rgb0_out          <= rgb0_in;
                rgb1_out          <= rgb1_in;
                pixel_counter_out <= pixel_counter_out + PW'(1);
              end
            end
          end
        end
        BLANK: begin
          addr_out  <= line_counter_out[AW-1:0];
          latch_out <= 1'b1;
        end
        LATCH: begin
          latch_out <= 1'b0;
          oe_n_out  <= 1'b0;
          disp_cnt  <= '0;
        end
        DISPLAY: begin
          if (disp_done) begin
            oe_n_out          <= 1'b1;
            pixel_counter_out <= '0;
            if (line_counter_out == LINE_LAST) begin
              line_counter_out <= '0;
              frame_done_out   <= 1'b1;
            end else begin
              line_counter_out <= line_counter_out + LW'(1);
            end
          end else begin
            disp_cnt <= disp_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench: expected panel events are queued from a timing model,
// a negedge monitor pops and compares them as the panel signals appear.
module tb_hub75_scan_driver;

  localparam int NP = 128;
  localparam int NL = 32;
  localparam int HP = 1;
  localparam int DC = 64;
  localparam int P  = 2 * HP * NP + 2 + DC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] rgb0_in, rgb1_in, rgb0_out, rgb1_out;
  logic [7:0] pix;
  logic [5:0] line;
  logic       pclk, latch, oe_n, fd;
  logic [4:0] addr;

  logic       rst2 = 1'b0;
  logic       en2 = 1'b0;
  logic [2:0] rgb0_in2, rgb1_in2, rgb0_out2, rgb1_out2;
  logic [7:0] pix2;
  logic [5:0] line2;
  logic       pclk2, latch2, oe2, fd2;
  logic [4:0] addr2;

  logic [2:0] tbl0 [NP];
  logic [2:0] tbl1 [NP];

  assign rgb0_in  = tbl0[pix[6:0]] ^ line[2:0];
  assign rgb1_in  = tbl1[pix[6:0]] ^ line[2:0];
  assign rgb0_in2 = pix2[2:0];
  assign rgb1_in2 = ~pix2[2:0];

  hub75_scan_driver dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable),
    .rgb0_in(rgb0_in), .rgb1_in(rgb1_in),
    .pixel_counter_out(pix), .line_counter_out(line),
    .rgb0_out(rgb0_out), .rgb1_out(rgb1_out),
    .panel_clk_out(pclk), .latch_out(latch), .oe_n_out(oe_n),
    .addr_out(addr), .frame_done_out(fd)
  );

  hub75_scan_driver #(.HALF_PERIOD(3), .DISPLAY_CYCLES(1)) dut2 (
    .clk_in(clk), .rst_n_in(rst2), .enable_in(en2),
    .rgb0_in(rgb0_in2), .rgb1_in(rgb1_in2),
    .pixel_counter_out(pix2), .line_counter_out(line2),
    .rgb0_out(rgb0_out2), .rgb1_out(rgb1_out2),
    .panel_clk_out(pclk2), .latch_out(latch2), .oe_n_out(oe2),
    .addr_out(addr2), .frame_done_out(fd2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [2:0]  r0;
    logic [2:0]  r1;
  } rise_t;
  typedef struct {
    int unsigned cyc;
    int unsigned line;
  } lat_t;

  rise_t       rise_q[$];
  lat_t        lat_q[$];
  int unsigned fd_q[$];
  int unsigned lm = 0;

  // Monitor
  bit          mon_en = 0;
  logic        prev_pclk, prev_latch, prev_oe;
  logic [2:0]  held0, held1;
  int unsigned lat_run, oe_run, fd_exp;
  rise_t       rr;
  lat_t        lr;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (pclk && !prev_pclk) begin
        if (rise_q.size() == 0) chk("rise_unexpected", 1, 0);
        else begin
          rr = rise_q.pop_front();
          chk("rise_cycle", cyc, rr.cyc);
          chk("rise_rgb0", rgb0_out, rr.r0);
          chk("rise_rgb1", rgb1_out, rr.r1);
        end
        held0 = rgb0_out;
        held1 = rgb1_out;
      end else if (pclk && prev_pclk) begin
        chk("rgb0_stable_high", rgb0_out, held0);
        chk("rgb1_stable_high", rgb1_out, held1);
      end
      if (latch && !prev_latch) begin
        if (lat_q.size() == 0) chk("latch_unexpected", 1, 0);
        else begin
          lr = lat_q.pop_front();
          chk("latch_cycle", cyc, lr.cyc);
          chk("latch_addr", addr, lr.line);
          chk("latch_line_counter", line, lr.line);
          chk("latch_oe_n", oe_n, 1);
        end
      end
      if (latch) lat_run++;
      else if (prev_latch) begin
        chk("latch_width", lat_run, 1);
        lat_run = 0;
      end
      if (!oe_n) begin
        oe_run++;
        chk("oe_low_while_pclk", pclk, 0);
      end else if (!prev_oe) begin
        chk("display_len", oe_run, DC);
        oe_run = 0;
      end
      if (fd) begin
        if (fd_q.size() == 0) chk("frame_done_unexpected", 1, 0);
        else begin
          fd_exp = fd_q.pop_front();
          chk("frame_done_cycle", cyc, fd_exp);
        end
      end
      prev_pclk  = pclk;
      prev_latch = latch;
      prev_oe    = oe_n;
    end
  end

  // Reference model: line L started at cycle s has rise k at s+HP+2*HP*k,
  // latch at s+2*HP*NP+1, and (for the last line) frame_done at s+P.
  task automatic run_seg(input int unsigned n, input int unsigned drop);
    int unsigned s, base, lc;
    s = cyc + 1;
    for (int unsigned i = 0; i < n; i++) begin
      lc   = (lm + i) % NL;
      base = s + i * P;
      for (int unsigned k = 0; k < NP; k++)
        rise_q.push_back('{base + HP + 2 * HP * k, tbl0[k] ^ 3'(lc), tbl1[k] ^ 3'(lc)});
      lat_q.push_back('{base + 2 * HP * NP + 1, lc});
      if (lc == NL - 1) fd_q.push_back(base + P);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("start_pixel", pix, 0);
    chk("start_line", line, lm);
    while (cyc < s + (n - 1) * P + 2 * HP * drop) @(negedge clk);
    enable = 1'b0;
    while (cyc < s + n * P + 4) @(negedge clk);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_pclk", pclk, 0);
    chk("idle_pixel", pix, 0);
    chk("idle_line", line, (lm + n) % NL);
    lm = (lm + n) % NL;
  endtask

  // Second instance: HALF_PERIOD=3, DISPLAY_CYCLES=1
  bit          d2_done = 0;
  logic        p2_prev = 1'b0;
  bit          seen2 = 0;
  int unsigned run2 = 0, nh2 = 0, orun2 = 0, nl2 = 0, s2 = 0;
  int unsigned lat2 [2];
  logic        l2_prev = 1'b0;

  initial begin
    repeat (4) @(negedge clk);
    rst2 = 1'b1;
    en2  = 1'b1;
    s2   = cyc + 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pclk2 != p2_prev) begin
        if (seen2 && nh2 < 10) begin
          chk(p2_prev ? "hp3_high_len" : "hp3_low_len", run2, 3);
          nh2++;
        end
        if (pclk2) seen2 = 1;
        run2 = 1;
      end else begin
        run2++;
      end
      if (latch2 && !l2_prev && nl2 < 2) begin
        lat2[nl2] = cyc;
        nl2++;
      end
      if (!oe2) orun2++;
      else if (orun2 != 0) begin
        chk("hp3_display_len", orun2, 1);
        orun2 = 0;
      end
      p2_prev = pclk2;
      l2_prev = latch2;
    end
    chk("hp3_latch_count", nl2, 2);
    if (nl2 == 2) begin
      chk("hp3_first_latch", lat2[0], s2 + 2 * 3 * NP + 1);
      chk("hp3_line_period", lat2[1] - lat2[0], 2 * 3 * NP + 2 + 1);
    end
    d2_done = 1;
  end

  initial begin
    for (int k = 0; k < NP; k++) begin
      tbl0[k] = 3'(k);
      tbl1[k] = ~3'(k);
    end
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && pix != 8'd40; i++) @(negedge clk);
    chk("reach_pixel40", pix, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_oe_n", oe_n, 1);
    chk("rst_pclk", pclk, 0);
    chk("rst_pixel", pix, 0);
    chk("rst_line", line, 0);
    chk("rst_latch", latch, 0);
    chk("rst_rgb0", rgb0_out, 0);
    chk("rst_addr", addr, 0);
    chk("rst_frame_done", fd, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_pixel", pix, 0);
    #2;
    rst_n      = 1'b1;
    prev_pclk  = 1'b0;
    prev_latch = 1'b0;
    prev_oe    = 1'b1;
    lat_run    = 0;
    oe_run     = 0;
    mon_en     = 1;
    run_seg(3, 60);
    repeat (20) @(negedge clk);
    chk("idle_hold_pixel", pix, 0);
    chk("idle_hold_line", line, 3);
    run_seg(3, $urandom_range(NP - 1));
    for (int k = 0; k < NP; k++) begin
      tbl0[k] = 3'($urandom);
      tbl1[k] = 3'($urandom);
    end
    run_seg(1 + $urandom_range(1), $urandom_range(NP - 1));
    run_seg((NL - lm) + NL + 1, $urandom_range(NP - 1));
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5000 && !d2_done; i++) @(negedge clk);
    chk("dut2_complete", d2_done, 1);
    chk("rise_queue_empty", rise_q.size(), 0);
    chk("latch_queue_empty", lat_q.size(), 0);
    chk("frame_done_queue_empty", fd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Sequential HUB75 scan engine sitting directly upstream of the combinational face-sprite stage.
- Generates pixel_counter/line_counter for that stage and registers its rgb0/rgb1 result.
- Shifts one full row pair into the panel, then blanks, latches, addresses and displays it, line by line.
- Drives the 128x64 panel as 32 scanned line pairs: rgb0 feeds the top half and rgb1 the bottom half.

Parameters:
- NUM_PIXELS, 128, columns shifted per line.
- NUM_LINES, 32, scanned line pairs per frame.
- HALF_PERIOD, 1, system cycles per panel-clock half period (>=1).
- DISPLAY_CYCLES, 64, cycles oe_n is held low per line (>=1).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- enable_in  input  1  run scanning; sampled in IDLE and at end of each line.
- rgb0_in  input  3  top-half colour for the current counters, combinational from the sprite stage.
- rgb1_in  input  3  bottom-half colour, same timing as rgb0_in.
- pixel_counter_out  output  $clog2(NUM_PIXELS)+1  column index to the sprite stage.
- line_counter_out  output  $clog2(NUM_LINES)+1  line index to the sprite stage.
- rgb0_out  output  3  panel R0/G0/B0.
- rgb1_out  output  3  panel R1/G1/B1.
- panel_clk_out  output  1  panel shift clock.
- latch_out  output  1  panel LAT.
- oe_n_out  output  1  panel output enable, active-low.
- addr_out  output  $clog2(NUM_LINES)  panel row address A..E.
- frame_done_out  output  1  single-cycle pulse after the last line's display.

Behaviour:
- Reset (async, rst_n_in=0, any state): state=IDLE; all counters, rgb outputs, panel_clk_out, latch_out, addr_out and frame_done_out = 0; oe_n_out=1. Release takes effect on the next clk_in edge.
- All outputs are registered. rgb_in is combinational on pixel_counter_out/line_counter_out, so the counters run one pixel ahead of rgb_out.
- IDLE: oe_n_out=1, panel_clk_out=0. When enable_in=1, go to SHIFT with pixel_counter_out=0 and line_counter_out=L (L=0 after reset).
- SHIFT:
  - Each pixel edge (SHIFT entry, or end of a high half): rgb0_out<=rgb0_in, rgb1_out<=rgb1_in, pixel_counter_out++, panel_clk_out<=0.
  - After HALF_PERIOD cycles, panel_clk_out<=1. After HALF_PERIOD more cycles, take the next pixel edge.
  - After the NUM_PIXELS-th high half: panel_clk_out<=0 and go to BLANK.
  - pixel_counter_out ends at NUM_PIXELS (no wrap); rgb_in at that value is ignored.
- oe_n_out during SHIFT: stays 0 (previous line still displayed) only if the previous DISPLAY has not expired; per-line mode is non-overlapped, so oe_n_out=1 throughout SHIFT.
- BLANK (1 cycle): oe_n_out=1, addr_out<=L[$clog2(NUM_LINES)-1:0].
- LATCH (1 cycle): latch_out=1, asserted only here; rgb and addr are stable.
- DISPLAY (DISPLAY_CYCLES cycles): latch_out=0, oe_n_out=0. At its end:
  - oe_n_out<=1 and pixel_counter_out<=0.
  - If L==NUM_LINES-1: L<=0 and frame_done_out=1 for one cycle; otherwise L++.
  - Then go to SHIFT if enable_in=1, else IDLE.
- Deasserting enable_in mid-line finishes the current line, then goes to IDLE.
- Line period = 2*HALF_PERIOD*NUM_PIXELS + 2 + DISPLAY_CYCLES; defaults give 322 cycles per line and 10304 cycles per frame.
- Width rules: counter compares are unsigned at full port width; the DISPLAY counter width is $clog2(DISPLAY_CYCLES+1).

Decomposition:
- Package hub75_pkg holds the state enum (IDLE, SHIFT, BLANK, LATCH, DISPLAY) and the localparam widths PIX_W and LINE_W.
- One sub-module, hub75_half_tick: HALF_PERIOD down-counter producing a one-cycle tick, reset by state entry. Everything else stays in one always_ff FSM.

Test Plan:
- Reset mid-SHIFT (pixel 40), defaults: oe_n_out=1, panel_clk_out=0, counters=0 immediately, without waiting for a clock edge. After release with enable_in=1, SHIFT starts at pixel 0, line 0.
- Model rgb0_in = pixel_counter[2:0] and rgb1_in = ~pixel_counter[2:0]:
  - Exactly 128 panel_clk_out rising edges in line 0.
  - On each rise k (0..127), rgb0_out == k[2:0] and rgb1_out == ~k[2:0].
  - rgb outputs are stable for the full high half.
- Line 5 sequence: latch_out high for exactly 1 cycle with oe_n_out=1 and addr_out=5 at that cycle. Then oe_n_out low for 64 cycles, and oe_n_out never low while panel_clk_out toggles.
- Free-run defaults: frame_done_out pulses once per 10304 cycles; line_counter_out goes 31 -> 0 and addr_out goes 31 -> 0 across the wrap.
- HALF_PERIOD=3, DISPLAY_CYCLES=1: each panel_clk_out half-period is 3 cycles; line period = 771 cycles.
- enable_in dropped at pixel 60 of line 2: line 2 completes (latch, 64-cycle display), then IDLE with oe_n_out=1. Re-enable resumes at line 3, pixel 0.
